// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, slave FSM states and byte-lane mask helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    // Little-endian lane enables for a transfer of the given size at byte offset a.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        return size == HSIZE_BYTE ? 4'b0001 << a :
               size == HSIZE_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: 2**AW x 32 memory with per-byte synchronous write and combinational read.
module ahb_sram_mem #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with wait states, two-cycle ERROR and write forwarding.
// Define AHB_SRAM_PROT_CHECK_EN to reject user-mode writes to the upper half of the memory.
module ahb_sram_slave import ahb_pkg::*; #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HSEL,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [2:0]  WS        = 3'(WAIT_STATES);

    state_t        state, state_nx;
    logic [2:0]    wcnt;
    logic [AW-1:0] d_word, a_word, r_word;
    logic [3:0]    d_mask;
    logic          d_write, start, illegal, prot_err, we, load, from_wait, unused;
    logic [31:0]   offset, rd_data, m32, fwd;

    assign offset  = HADDR - BASE_ADDR;
    assign a_word  = offset[AW+1:2];
    assign start   = HSEL && (HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ}) && HREADYOUT;

`ifdef AHB_SRAM_PROT_CHECK_EN
    assign prot_err = HWRITE && !HPROT[1] && offset >= MEM_BYTES / 2;
    assign unused   = ^{HBURST, HMASTLOCK, HPROT[3:2], HPROT[0]};
`else
    assign prot_err = 1'b0;
    assign unused   = ^{HBURST, HMASTLOCK, HPROT};
`endif

    assign illegal = HADDR < BASE_ADDR || offset >= MEM_BYTES || HSIZE > HSIZE_WORD ||
                     (HSIZE == HSIZE_HALF && HADDR[0]) ||
                     (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00) || prot_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            d_word  <= '0;
            d_mask  <= '0;
            d_write <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt  <= state == ST_WAIT ? wcnt - 3'd1 : WS - 3'd1;
            if (start) begin
                d_word  <= a_word;
                d_mask  <= lane_mask(HSIZE, HADDR[1:0]);
                d_write <= HWRITE;
            end
        end
    end

    // IDLE, DATA and ERR2 all present HREADYOUT=1, so each may take the next address phase.
    always_comb begin
        state_nx = state;
        case (state)
            ST_WAIT: state_nx = wcnt == 3'd0 ? ST_DATA : ST_WAIT;
            ST_ERR1: state_nx = ST_ERR2;
            default: state_nx = !start ? ST_IDLE : illegal ? ST_ERR1 :
                                WS != 3'd0 ? ST_WAIT : ST_DATA;
        endcase
    end

    always_comb begin
        HREADYOUT = !(state inside {ST_WAIT, ST_ERR1});
        HRESP     = state inside {ST_ERR1, ST_ERR2} ? HRESP_ERROR : HRESP_OKAY;
    end

    // Read data is captured on entry to DATA; a write committing on that same edge is merged in.
    assign we        = state == ST_DATA && d_write;
    assign from_wait = state == ST_WAIT;
    assign r_word    = from_wait ? d_word : a_word;
    assign load      = state_nx == ST_DATA && !(from_wait ? d_write : HWRITE);
    assign m32       = {{8{d_mask[3]}}, {8{d_mask[2]}}, {8{d_mask[1]}}, {8{d_mask[0]}}};
    assign fwd       = we && d_word == r_word ? (rd_data & ~m32) | (HWDATA & m32) : rd_data;

    always_ff @(posedge clk or negedge rst)
        if (!rst) HRDATA <= '0;
        else if (load) HRDATA <= fwd;

    ahb_sram_mem #(.AW(AW)) u_mem (
        .clk   (clk),
        .we    (we),
        .be    (d_mask),
        .waddr (d_word),
        .wdata (HWDATA),
        .raddr (r_word),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: table-driven pipelined AHB master against two slaves (0 and 2 wait states).
module tb_ahb_sram_slave;
    import ahb_pkg::*;

`ifdef AHB_SRAM_PROT_CHECK_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef struct {
        bit          sel, wr, err, chk;
        logic [1:0]  tr;
        logic [31:0] a, wd, rd;
        logic [2:0]  sz;
        logic [3:0]  pr;
    } rec_t;

    typedef struct {
        int          idx, waits;
        bit          err, chk;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] haddr [2], hwdata [2], hrdata [2];
    logic        hwrite [2], hsel [2], hmastlock [2], hready [2], hresp [2];
    logic [2:0]  hsize [2], hburst [2];
    logic [3:0]  hprot [2];
    logic [1:0]  htrans [2];
    int          ws [2] = '{0, 2};
    int          checks = 0, errors = 0;
    rec_t        tbl [$];
    exp_t        sb [$];

    always #10 clk = ~clk;

    ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .HADDR(haddr[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
        .HBURST(hburst[0]), .HPROT(hprot[0]), .HTRANS(htrans[0]), .HMASTLOCK(hmastlock[0]),
        .HWDATA(hwdata[0]), .HSEL(hsel[0]), .HREADYOUT(hready[0]), .HRESP(hresp[0]),
        .HRDATA(hrdata[0])
    );

    ahb_sram_slave #(.WAIT_STATES(2)) dut1 (
        .clk(clk), .rst(rst), .HADDR(haddr[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
        .HBURST(hburst[1]), .HPROT(hprot[1]), .HTRANS(htrans[1]), .HMASTLOCK(hmastlock[1]),
        .HWDATA(hwdata[1]), .HSEL(hsel[1]), .HREADYOUT(hready[1]), .HRESP(hresp[1]),
        .HRDATA(hrdata[1])
    );

    function automatic rec_t mk(bit sel, bit wr, logic [1:0] tr, logic [31:0] a, logic [2:0] sz,
                                logic [3:0] pr, logic [31:0] wd, bit err, logic [31:0] rd);
        rec_t r;
        r.sel = sel; r.wr = wr; r.tr = tr; r.a = a; r.sz = sz; r.pr = pr; r.wd = wd;
        r.err = err; r.rd = rd;
        r.chk = sel && tr[1] && (!wr || err);
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive_addr(input int b, input int i, input int last);
        exp_t e;
        if (i > last) begin
            hsel[b] = 1'b0;
            htrans[b] = HTRANS_IDLE;
            return;
        end
        hsel[b] = tbl[i].sel; hwrite[b] = tbl[i].wr; htrans[b] = tbl[i].tr; haddr[b] = tbl[i].a;
        hsize[b] = tbl[i].sz; hprot[b] = tbl[i].pr; hburst[b] = 3'(i); hmastlock[b] = i[0];
        e.idx = i; e.err = tbl[i].err; e.chk = tbl[i].chk; e.rd = tbl[i].rd;
        e.waits = tbl[i].err ? 1 : (tbl[i].sel && tbl[i].tr[1]) ? ws[b] : 0;
        sb.push_back(e);
    endtask

    // Pipelined master: issues tbl[first..last] back to back, scoreboarding each data phase.
    task automatic run(input int b, input int first, input int last);
        int   i = first, waits = 0, guard = 0;
        bit   act = 1'b0, acc, lowresp = 1'b0;
        exp_t e;
        drive_addr(b, i, last);
        while ((i <= last || act) && guard < 300) begin
            @(negedge clk);
            guard++;
            if (act && !hready[b]) begin
                waits++;
                lowresp |= hresp[b];
            end else if (act) begin
                e = sb.pop_front();
                check("waits", e.idx, 32'(waits), 32'(e.waits));
                check("hresp", e.idx, 32'(hresp[b]), 32'(e.err));
                if (waits > 0) check("hresp_wait", e.idx, 32'(lowresp), 32'(e.err));
                if (e.chk) check("hrdata", e.idx, hrdata[b], e.rd);
                act = 1'b0;
            end
            acc = hready[b] && i <= last;
            @(posedge clk);
            #1;
            if (acc) begin
                hwdata[b] = tbl[i].wd;
                act = 1'b1; waits = 0; lowresp = 1'b0;
                i++;
                drive_addr(b, i, last);
            end
        end
        if (guard >= 300) begin
            checks++; errors++;
            $display("FAIL timeout: bus %0d stuck at record %0d, required completion", b, i);
            sb.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int b = 0; b < 2; b++) begin
            hsel[b] = 0; htrans[b] = HTRANS_IDLE; haddr[b] = 0; hwrite[b] = 0; hsize[b] = 0;
            hburst[b] = 0; hprot[b] = 0; hmastlock[b] = 0; hwdata[b] = 0;
        end
        // bus 0: zero wait states, records 0..22
        tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h10,   HSIZE_WORD, 4'h3, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h10,   HSIZE_WORD, 4'h3, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mk(1, 1, HTRANS_SEQ,    32'h10,   HSIZE_WORD, 4'h3, 32'h11223344, 0, 0));
        tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h13,   HSIZE_BYTE, 4'h3, 32'hAA5A5A5A, 0, 0));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h10,   HSIZE_WORD, 4'h3, 0, 0, 32'hAA223344));
        tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h10,   HSIZE_HALF, 4'h3, 32'h99995566, 0, 0));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h10,   HSIZE_WORD, 4'h3, 0, 0, 32'hAA225566));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h11,   HSIZE_BYTE, 4'h3, 0, 0, 32'hAA225566));
        tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h00,   HSIZE_WORD, 4'h3, 32'hCAFEF00D, 0, 0));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h1000, HSIZE_WORD, 4'h3, 0, 1, 32'hAA225566));
        tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h02,   HSIZE_WORD, 4'h3, 32'h12345678, 1, 32'hAA225566));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h00,   3'd3,       4'h3, 0, 1, 32'hAA225566));
        tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h01,   HSIZE_HALF, 4'h3, 32'h77777777, 1, 32'hAA225566));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h00,   HSIZE_WORD, 4'h3, 0, 0, 32'hCAFEF00D));
        tbl.push_back(mk(1, 0, HTRANS_IDLE,   32'h10,   HSIZE_WORD, 4'h3, 0, 0, 0));
        tbl.push_back(mk(0, 1, HTRANS_NONSEQ, 32'h10,   HSIZE_WORD, 4'h3, 32'hFFFFFFFF, 0, 0));
        tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'hFFC,  HSIZE_WORD, 4'h3, 32'h0BADCAFE, 0, 0));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'hFFC,  HSIZE_WORD, 4'h3, 0, 0, 32'h0BADCAFE));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h10,   HSIZE_WORD, 4'h3, 0, 0, 32'hAA225566));
        tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h800,  HSIZE_WORD, 4'h3, 32'h66666666, 0, 0));
        tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h800,  HSIZE_WORD, 4'h1, 32'h55555555, PROT, 32'hAA225566));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h800,  HSIZE_WORD, 4'h1, 0, 0,
                         PROT ? 32'h66666666 : 32'h55555555));
        tbl.push_back(mk(1, 0, HTRANS_BUSY,   32'h800,  HSIZE_WORD, 4'h3, 0, 0, 0));
        // bus 1: two wait states, records 23..29, then 30 after the mid-transfer reset
        tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h20,   HSIZE_WORD, 4'h3, 32'h13579BDF, 0, 0));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h20,   HSIZE_WORD, 4'h3, 0, 0, 32'h13579BDF));
        tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h21,   HSIZE_BYTE, 4'h3, 32'h0000AA00, 0, 0));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h20,   HSIZE_WORD, 4'h3, 0, 0, 32'h1357AADF));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h1000, HSIZE_WORD, 4'h3, 0, 1, 32'h1357AADF));
        tbl.push_back(mk(1, 1, HTRANS_NONSEQ, 32'h40,   HSIZE_WORD, 4'h3, 32'h01020304, 0, 0));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h40,   HSIZE_WORD, 4'h3, 0, 0, 32'h01020304));
        tbl.push_back(mk(1, 0, HTRANS_NONSEQ, 32'h40,   HSIZE_WORD, 4'h3, 0, 0, 32'h01020304));

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int b = 0; b < 2; b++) begin
                check("rst_hready", b, 32'(hready[b]), 32'd1);
                check("rst_hresp", b, 32'(hresp[b]), 32'd0);
                check("rst_hrdata", b, hrdata[b], 32'd0);
            end
        end
        #15 rst = 1'b1;
        @(posedge clk);
        #1;
        run(0, 0, 22);
        run(1, 23, 29);

        // Reset during a wait-stated write: outputs return to reset values, write is dropped.
        hsel[1] = 1'b1; hwrite[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; haddr[1] = 32'h40;
        hsize[1] = HSIZE_WORD; hprot[1] = 4'h3;
        @(posedge clk);
        #1;
        hsel[1] = 1'b0; htrans[1] = HTRANS_IDLE; hwdata[1] = 32'hFFFFFFFF;
        @(negedge clk);
        check("midrst_wait", 0, 32'(hready[1]), 32'd0);
        rst = 1'b0;
        #2;
        check("midrst_hready", 0, 32'(hready[1]), 32'd1);
        check("midrst_hresp", 0, 32'(hresp[1]), 32'd0);
        check("midrst_hrdata", 0, hrdata[1], 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run(1, 30, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
